// File: rtl/siso_arb_ctrl_if.sv
// Handshake and serial-out bundle between two parallel producers and the shift-out arbiter.
interface siso_arb_ctrl_if #(
   parameter int WIDTH = 8
) ();
   logic             req0;
   logic [WIDTH-1:0] data0;
   logic             req1;
   logic [WIDTH-1:0] data1;
   logic             ack0;
   logic             ack1;
   logic             sout;
   logic             frame;
   logic             owner;
   logic             busy;
   logic             done;

   modport master (
      output req0, data0, req1, data1,
      input  ack0, ack1, sout, frame, owner, busy, done
   );

   modport slave (
      input  req0, data0, req1, data1,
      output ack0, ack1, sout, frame, owner, busy, done
   );
endinterface

// File: rtl/siso_arb_ctrl.sv
// Two-requester round-robin arbiter that captures the winner's word and shifts it out MSB-first.
//   state   | meaning
//   S_IDLE  | waiting for a request; arbitrates and captures at the sampling edge
//   S_SHIFT | frame active, one bit per cycle on sout
//   S_GAP   | one-cycle post-frame slot carrying the done pulse
module siso_arb_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   siso_arb_ctrl_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic             frame_q, frame_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   // last resets to 1 so requester 0 wins the first contention
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         frame_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         frame_q <= frame_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   logic win;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      owner_d = owner_q;
      last_d  = last_q;
      frame_d = frame_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      win     = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
      unique case (state_q)
         S_IDLE: begin
            frame_d = 1'b0;
            busy_d  = 1'b0;
            if (bus.req0 | bus.req1) begin
               shreg_d = win ? bus.data1 : bus.data0;
               ack0_d  = ~win;
               ack1_d  = win;
               owner_d = win;
               last_d  = win;
               cnt_d   = '0;
               frame_d = 1'b1;
               busy_d  = 1'b1;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               frame_d = 1'b0;
               done_d  = 1'b1;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            frame_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.ack0  = ack0_q;
   assign bus.ack1  = ack1_q;
   assign bus.sout  = frame_q & shreg_q[WIDTH-1];
   assign bus.frame = frame_q;
   assign bus.owner = owner_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_siso_arb_ctrl.sv
// Directed bench for siso_arb_ctrl: reset, contention, lone requester, late request, mid-frame reset.
module tb_siso_arb_ctrl;
   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   siso_arb_ctrl_if #(.WIDTH(8)) bus ();

   siso_arb_ctrl #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_sout"},  32'(bus.sout),  0);
      chk({tag, "_frame"}, 32'(bus.frame), 0);
      chk({tag, "_ack0"},  32'(bus.ack0),  0);
      chk({tag, "_ack1"},  32'(bus.ack1),  0);
      chk({tag, "_busy"},  32'(bus.busy),  0);
      chk({tag, "_done"},  32'(bus.done),  0);
      chk({tag, "_owner"}, 32'(bus.owner), 0);
   endtask

   // Entered in the ack cycle of a frame; leaves in the following IDLE cycle.
   task automatic expect_frame(input logic w, input logic [7:0] word,
                               input int raise1_at, input logic [7:0] late_data);
      chk("ack_win",   32'(w ? bus.ack1 : bus.ack0), 1);
      chk("ack_other", 32'(w ? bus.ack0 : bus.ack1), 0);
      chk("owner",     32'(bus.owner), 32'(w));
      for (int i = 0; i < 8; i++) begin
         if (i > 0) begin
            tick();
            chk("ack_clear", 32'({bus.ack0, bus.ack1}), 0);
         end
         if (i == raise1_at) begin
            bus.req1  = 1'b1;
            bus.data1 = late_data;
         end
         chk("frame_on", 32'(bus.frame), 1);
         chk("sout_bit", 32'(bus.sout), 32'(word[7-i]));
         chk("busy_on",  32'(bus.busy), 1);
         chk("done_off", 32'(bus.done), 0);
      end
      tick();
      chk("gap_frame", 32'(bus.frame), 0);
      chk("gap_sout",  32'(bus.sout), 0);
      chk("gap_done",  32'(bus.done), 1);
      chk("gap_busy",  32'(bus.busy), 1);
      chk("gap_ack",   32'({bus.ack0, bus.ack1}), 0);
      tick();
      chk("idle_frame", 32'(bus.frame), 0);
      chk("idle_done",  32'(bus.done), 0);
      chk("idle_busy",  32'(bus.busy), 0);
      chk("idle_ack",   32'({bus.ack0, bus.ack1}), 0);
      chk("idle_owner", 32'(bus.owner), 32'(w));
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.req0  = 1'b0;
      bus.req1  = 1'b0;
      bus.data0 = 8'h00;
      bus.data1 = 8'h00;
      tick();
      tick();
      chk_idle_outs("reset");

      // Release reset together with contention; grants must alternate 0,1,0,1.
      rst       = 1'b0;
      bus.req0  = 1'b1;
      bus.req1  = 1'b1;
      bus.data0 = 8'h3C;
      bus.data1 = 8'hC3;
      tick();
      expect_frame(1'b0, 8'h3C, -1, 8'h00);
      tick();
      expect_frame(1'b1, 8'hC3, -1, 8'h00);
      tick();
      expect_frame(1'b0, 8'h3C, -1, 8'h00);
      tick();
      expect_frame(1'b1, 8'hC3, -1, 8'h00);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      tick();
      chk("no_req_idle", 32'({bus.ack0, bus.ack1, bus.frame, bus.busy}), 0);

      // Lone requester 1 is granted back to back every 10 cycles.
      bus.req1  = 1'b1;
      bus.data1 = 8'hFF;
      tick();
      expect_frame(1'b1, 8'hFF, -1, 8'h00);
      tick();
      expect_frame(1'b1, 8'hFF, -1, 8'h00);
      bus.req1 = 1'b0;
      tick();

      // Single grant of A5, then a late requester 1 raised during bit 3 of another A5 frame.
      bus.req0  = 1'b1;
      bus.data0 = 8'hA5;
      tick();
      bus.req0 = 1'b0;
      expect_frame(1'b0, 8'hA5, -1, 8'h00);
      bus.req0 = 1'b1;
      tick();
      bus.req0 = 1'b0;
      expect_frame(1'b0, 8'hA5, 3, 8'h5A);
      tick();
      bus.req1 = 1'b0;
      expect_frame(1'b1, 8'h5A, -1, 8'h00);

      // Reset during bit 4 of an A5 frame with req0 still held.
      bus.req0 = 1'b1;
      tick();
      chk("pre_rst_ack0", 32'(bus.ack0), 1);
      for (int i = 0; i < 4; i++) tick();
      chk("pre_rst_frame", 32'(bus.frame), 1);
      chk("pre_rst_busy",  32'(bus.busy), 1);
      rst = 1'b1;
      #1;
      chk_idle_outs("async_rst");
      tick();
      chk_idle_outs("held_rst");
      rst = 1'b0;
      tick();
      expect_frame(1'b0, 8'hA5, -1, 8'h00);
      bus.req0 = 1'b0;
      tick();
      chk("final_idle", 32'({bus.ack0, bus.ack1, bus.frame, bus.busy, bus.done}), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
